// File: rtl/gray_ptr_rx.sv
// -----------------------------------------------------------------------------
// gray_ptr_rx
// Receiving end of a FIFO gray-pointer crossing. The peer side's gray pointer
// is synchronized with two flops, a third flop keeps the previous sample so
// each step can be checked for gray legality, and legal samples are decoded
// to binary. The decoded peer pointer is compared with the local binary
// pointer to give fill level, full/empty, almost-full/almost-empty and a
// sticky protocol-error flag.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   peer_g     in   ptr_w+1  peer gray pointer (asynchronous to clk)
//   own_b      in   ptr_w+1  local binary pointer (synchronous to clk)
//   err_clr    in   1        clears gray_err (a new error in the same cycle wins)
//   peer_b     out  ptr_w+1  synchronized, decoded peer pointer (registered)
//   peer_vld   out  1        sync pipeline primed; flags and errors valid
//   level      out  ptr_w+1  occupancy (combinational from own_b and peer_b)
//   full       out  1        level == 2**ptr_w (write side only)
//   empty      out  1        own_b == peer_b (read side only)
//   alm_full   out  1        registered, level >= AF_LVL
//   alm_empty  out  1        registered, level <= AE_LVL
//   gray_err   out  1        sticky: illegal gray step or level out of range
// -----------------------------------------------------------------------------
module gray_ptr_rx #(
  parameter int ptr_w  = 3,
  parameter bit IS_WR  = 1'b1,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ptr_w:0]   peer_g,
  input  logic [ptr_w:0]   own_b,
  input  logic             err_clr,
  output logic [ptr_w:0]   peer_b,
  output logic             peer_vld,
  output logic [ptr_w:0]   level,
  output logic             full,
  output logic             empty,
  output logic             alm_full,
  output logic             alm_empty,
  output logic             gray_err
);

  localparam int PW = ptr_w + 1;
  localparam logic [PW-1:0] DEPTH  = {1'b1, {ptr_w{1'b0}}};
  localparam logic [PW-1:0] AF_V   = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_V   = PW'(AE_LVL);
  localparam logic [PW-1:0] ONE_V  = {{(PW-1){1'b0}}, 1'b1};

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  // True when more than one bit is set (v & (v-1) clears the lowest set bit).
  function automatic logic multi_bit(input logic [PW-1:0] v);
    return ((v & (v - ONE_V)) != {PW{1'b0}});
  endfunction

  logic [PW-1:0] s1_q, s2_q, s3_q;
  logic [PW-1:0] peer_b_q, peer_b_d;
  logic [1:0]    prime_q, prime_d;
  logic          err_q, err_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;

  logic          vld_s;
  logic          step_bad_s;
  logic [PW-1:0] level_s;
  logic          full_s;
  logic          empty_s;

  // Next-state and combinational flag logic.
  always_comb begin
    vld_s      = (prime_q == 2'd3);
    step_bad_s = multi_bit(s2_q ^ s3_q);

    if (IS_WR) begin
      level_s = own_b - peer_b_q;
    end else begin
      level_s = peer_b_q - own_b;
    end

    // Write side: same slot, opposite wrap bit. Read side never reports full.
    if (IS_WR) begin
      full_s  = (own_b[ptr_w] != peer_b_q[ptr_w]) &&
                (own_b[ptr_w-1:0] == peer_b_q[ptr_w-1:0]);
      empty_s = 1'b0;
    end else begin
      full_s  = 1'b0;
      empty_s = (own_b == peer_b_q);
    end

    // An illegal sample may be a mid-transition capture; keep the last good value.
    if (step_bad_s) begin
      peer_b_d = peer_b_q;
    end else begin
      peer_b_d = gray2bin(s2_q);
    end

    if (prime_q != 2'd3) begin
      prime_d = prime_q + 2'd1;
    end else begin
      prime_d = prime_q;
    end

    // Set has priority over clear so a coincident error is never lost.
    if (vld_s && (step_bad_s || (level_s > DEPTH))) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    af_d = (level_s >= AF_V);
    ae_d = (level_s <= AE_V);
  end

  // Synchronizer, history, decoded pointer, prime counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= {PW{1'b0}};
      s2_q     <= {PW{1'b0}};
      s3_q     <= {PW{1'b0}};
      peer_b_q <= {PW{1'b0}};
      prime_q  <= 2'd0;
      err_q    <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      s1_q     <= peer_g;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      peer_b_q <= peer_b_d;
      prime_q  <= prime_d;
      err_q    <= err_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign peer_b    = peer_b_q;
  assign peer_vld  = vld_s;
  assign level     = level_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign alm_full  = af_q;
  assign alm_empty = ae_q;
  assign gray_err  = err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_rx
// Two instances (write side and read side, ptr_w=3) share the same inputs.
// A stimulus process drives directed scenarios followed by random traffic and,
// on every clock edge, advances a behavioural model and pushes the expected
// outputs into a scoreboard queue. A monitor process pops and compares.
// -----------------------------------------------------------------------------
module tb_gray_ptr_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] peer_g;
  logic [3:0] own_b;
  logic       err_clr;

  logic [3:0] w_pb, w_lvl, r_pb, r_lvl;
  logic       w_vld, w_full, w_empty, w_af, w_ae, w_err;
  logic       r_vld, r_full, r_empty, r_af, r_ae, r_err;

  always #5 clk = ~clk;

  gray_ptr_rx #(.ptr_w(3), .IS_WR(1'b1), .AF_LVL(6), .AE_LVL(2)) u_wr (
    .clk(clk), .rst_n(rst_n), .peer_g(peer_g), .own_b(own_b), .err_clr(err_clr),
    .peer_b(w_pb), .peer_vld(w_vld), .level(w_lvl), .full(w_full), .empty(w_empty),
    .alm_full(w_af), .alm_empty(w_ae), .gray_err(w_err)
  );

  gray_ptr_rx #(.ptr_w(3), .IS_WR(1'b0), .AF_LVL(6), .AE_LVL(2)) u_rd (
    .clk(clk), .rst_n(rst_n), .peer_g(peer_g), .own_b(own_b), .err_clr(err_clr),
    .peer_b(r_pb), .peer_vld(r_vld), .level(r_lvl), .full(r_full), .empty(r_empty),
    .alm_full(r_af), .alm_empty(r_ae), .gray_err(r_err)
  );

  typedef struct {
    logic [3:0] pb;
    logic       vld;
    logic [3:0] lw;
    logic [3:0] lr;
    logic       fw;
    logic       er;
    logic       afw, aew, afr, aer;
    logic       errw, errr;
  } exp_t;

  exp_t sb[$];
  event chk_now;
  int   n_vec = 0;
  int   n_bad = 0;

  // ---------------- behavioural model ----------------
  logic [3:0] hist[$];   // peer_g values seen at recent clock edges, oldest first
  int         nedge;     // edges since reset release (saturates at 3)
  logic [3:0] m_pb;
  logic       m_ew, m_er, m_afw, m_aew, m_afr, m_aer;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g;
    for (int s = 1; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    hist.delete();
    nedge = 0;
    m_pb  = 4'd0;
    m_ew  = 1'b0;
    m_er  = 1'b0;
    m_afw = 1'b0;
    m_afr = 1'b0;
    m_aew = 1'b1;
    m_aer = 1'b1;
  endtask

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    logic [3:0] cur, prev, lw, lr;
    logic       legal, vld;
    if (!rst_n) begin
      model_reset();
    end else begin
      // Sample the DUT decodes now is the one taken two edges ago; compare to the one before.
      cur   = (hist.size() >= 2) ? hist[hist.size()-2] : 4'd0;
      prev  = (hist.size() >= 3) ? hist[hist.size()-3] : 4'd0;
      legal = ($countones(cur ^ prev) <= 1);
      vld   = (nedge >= 3);
      lw    = own_b - m_pb;
      lr    = m_pb - own_b;
      if (vld && (!legal || lw > 4'd8)) m_ew = 1'b1;
      else if (err_clr)                 m_ew = 1'b0;
      if (vld && (!legal || lr > 4'd8)) m_er = 1'b1;
      else if (err_clr)                 m_er = 1'b0;
      m_afw = (lw >= 4'd6);
      m_aew = (lw <= 4'd2);
      m_afr = (lr >= 4'd6);
      m_aer = (lr <= 4'd2);
      if (legal) m_pb = g2b(cur);
      hist.push_back(peer_g);
      if (hist.size() > 3) void'(hist.pop_front());
      if (nedge < 3) nedge++;
    end
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    e.pb   = m_pb;
    e.vld  = (nedge >= 3);
    e.lw   = own_b - m_pb;
    e.lr   = m_pb - own_b;
    e.fw   = (e.lw == 4'd8);
    e.er   = (e.lr == 4'd0);
    e.afw  = m_afw;
    e.aew  = m_aew;
    e.afr  = m_afr;
    e.aer  = m_aer;
    e.errw = m_ew;
    e.errr = m_er;
    return e;
  endfunction

  // One clock: model follows the edge, expectation queued, inputs free to change.
  task automatic tick();
    @(posedge clk);
    model_edge();
    sb.push_back(mk_exp());
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_now);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr.peer_b",    w_pb,           e.pb);
        chk("wr.peer_vld",  4'(w_vld),      4'(e.vld));
        chk("wr.level",     w_lvl,          e.lw);
        chk("wr.full",      4'(w_full),     4'(e.fw));
        chk("wr.empty",     4'(w_empty),    4'd0);
        chk("wr.alm_full",  4'(w_af),       4'(e.afw));
        chk("wr.alm_empty", 4'(w_ae),       4'(e.aew));
        chk("wr.gray_err",  4'(w_err),      4'(e.errw));
        chk("rd.peer_b",    r_pb,           e.pb);
        chk("rd.peer_vld",  4'(r_vld),      4'(e.vld));
        chk("rd.level",     r_lvl,          e.lr);
        chk("rd.full",      4'(r_full),     4'd0);
        chk("rd.empty",     4'(r_empty),    4'(e.er));
        chk("rd.alm_full",  4'(r_af),       4'(e.afr));
        chk("rd.alm_empty", 4'(r_ae),       4'(e.aer));
        chk("rd.gray_err",  4'(r_err),      4'(e.errr));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] pbin;
  int         r;

  task automatic set_peer(input logic [3:0] b);
    pbin   = b;
    peer_g = b2g(b);
  endtask

  // Mid-cycle asynchronous reset with an immediate check, then release.
  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    model_reset();
    sb.push_back(mk_exp());
    -> chk_now;
    #1;
    ticks(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    peer_g  = 4'd0;
    own_b   = 4'd0;
    err_clr = 1'b0;
    pbin    = 4'd0;
    model_reset();

    // Reset, then prime: peer_vld on the third edge after release.
    ticks(2);
    rst_n = 1'b1;
    ticks(5);

    // Write side fills: own_b 1..8 with peer at 0.
    for (int i = 1; i <= 8; i++) begin
      own_b = 4'(i);
      tick();
    end
    ticks(3);

    // Read side: peer walks gray 0..5 with own_b at 0.
    err_clr = 1'b1;
    own_b   = 4'd0;
    tick();
    err_clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_peer(4'(i));
      tick();
    end
    ticks(4);

    // Wrap: peer to 9, own_b 15 -> 0.
    own_b = 4'd15;
    for (int i = 6; i <= 9; i++) begin
      set_peer(4'(i));
      tick();
    end
    ticks(4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    own_b   = 4'd0;
    ticks(4);

    // Illegal gray jump, clear, then clear coincident with a new bad step.
    set_peer(4'd0);
    own_b = 4'd0;
    pulse_reset(1);
    ticks(5);
    peer_g = 4'b0011;
    ticks(4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ticks(2);
    peer_g = 4'b1100;
    ticks(2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ticks(3);

    // Reset while full.
    set_peer(4'd0);
    pulse_reset(1);
    own_b = 4'd8;
    ticks(6);
    pulse_reset(2);
    ticks(5);

    // Random traffic: mostly legal peer steps, occasional corrupt jumps.
    set_peer(4'd0);
    own_b = 4'd0;
    for (int c = 0; c < 500; c++) begin
      tick();
      r = $urandom_range(0, 99);
      if (r < 4) begin
        peer_g = 4'($urandom);
        pbin   = g2b(peer_g);
      end else if (r < 50) begin
        set_peer(pbin + 4'd1);
      end
      r = $urandom_range(0, 99);
      if (r < 35)      own_b = own_b + 4'd1;
      else if (r < 40) own_b = 4'($urandom);
      err_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) pulse_reset(1);
    end
    err_clr = 1'b0;
    ticks(2);
    #3;

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
